// File: rtl/uc_sequencia_param_pkg.sv
// Shared encodings for the sequence-check control unit: 4-bit state codes
// (these double as the debug codes on db_estado) and the illegal-state code.
package uc_sequencia_pkg;

    localparam logic [3:0] ST_INICIAL     = 4'h0;
    localparam logic [3:0] ST_PREPARACAO  = 4'h1;
    localparam logic [3:0] ST_ESPERA      = 4'h2;
    localparam logic [3:0] ST_REGISTRA    = 4'h4;
    localparam logic [3:0] ST_COMPARACAO  = 4'h5;
    localparam logic [3:0] ST_PROXIMO     = 4'h6;
    localparam logic [3:0] ST_FIM_ACERTO  = 4'hA;
    localparam logic [3:0] ST_FIM_TIMEOUT = 4'hC;
    localparam logic [3:0] ST_FIM_ERRO    = 4'hE;

    localparam logic [3:0] DB_ILEGAL      = 4'hF;

    typedef enum logic [3:0] {
        INICIAL     = ST_INICIAL,
        PREPARACAO  = ST_PREPARACAO,
        ESPERA      = ST_ESPERA,
        REGISTRA    = ST_REGISTRA,
        COMPARACAO  = ST_COMPARACAO,
        PROXIMO     = ST_PROXIMO,
        FIM_ACERTO  = ST_FIM_ACERTO,
        FIM_TIMEOUT = ST_FIM_TIMEOUT,
        FIM_ERRO    = ST_FIM_ERRO
    } estado_t;

endpackage

// File: rtl/uc_sequencia_param_if.sv
// Control/status bundle between the top level + datapath (master) and the
// sequence control unit (slave).
interface uc_sequencia_param_if #(
    parameter int TIMEOUT_CYCLES = 5000
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic            iniciar;
    logic            jogada;
    logic            igual;
    logic            fimC;
    logic            modo_timeout;
    logic            zeraC;
    logic            zeraR;
    logic            contaC;
    logic            registraR;
    logic            pronto;
    logic            acertou;
    logic            errou;
    logic            timeout;
    logic [3:0]      db_estado;
    logic [TO_W-1:0] db_timeout;

    modport master (
        output iniciar, jogada, igual, fimC, modo_timeout,
        input  zeraC, zeraR, contaC, registraR, pronto, acertou, errou, timeout,
        input  db_estado, db_timeout
    );

    modport slave (
        input  iniciar, jogada, igual, fimC, modo_timeout,
        output zeraC, zeraR, contaC, registraR, pronto, acertou, errou, timeout,
        output db_estado, db_timeout
    );
endinterface

// File: rtl/uc_sequencia_param_contador_timeout.sv
// Saturating wait-time counter. clear has priority over enable; the count
// parks at TIMEOUT_CYCLES-1 so a frozen-then-resumed wait never wraps.
module contador_timeout #(
    parameter  int TIMEOUT_CYCLES = 5000,
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    output logic [TO_W-1:0] count,
    output logic            fim
);
    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] count_r;

    // Count register: clear, saturating increment, or hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign fim   = (count_r == LAST);
endmodule

// File: rtl/uc_sequencia_param.sv
// Moore control unit for the sequence-check game: wait for a move, register
// it, compare, advance; ends in pass, fail or timeout and restarts on iniciar.
// Outputs are flops loaded from the next state so they line up with the
// state register and never glitch.
module uc_sequencia_param
    import uc_sequencia_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                 clock,
    input  logic                 reset,
    uc_sequencia_param_if.slave  bus
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    estado_t         state_r;
    estado_t         next_state_s;
    logic [TO_W-1:0] count_s;
    logic            fim_s;

    logic            zera_c_r;
    logic            zera_r_r;
    logic            conta_c_r;
    logic            registra_r_r;
    logic            pronto_r;
    logic            acertou_r;
    logic            errou_r;
    logic            timeout_r;
    logic [3:0]      db_estado_r;

    contador_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_contador (
        .clock  (clock),
        .reset  (reset),
        .clear  (state_r != ESPERA),
        .enable (bus.modo_timeout),
        .count  (count_s),
        .fim    (fim_s)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= INICIAL;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a move in espera beats a simultaneous timeout.
    always_comb begin
        next_state_s = INICIAL;
        case (state_r)
            INICIAL:     next_state_s = bus.iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  next_state_s = ESPERA;
            ESPERA: begin
                if (bus.jogada) begin
                    next_state_s = REGISTRA;
                end else if (bus.modo_timeout && fim_s) begin
                    next_state_s = FIM_TIMEOUT;
                end else begin
                    next_state_s = ESPERA;
                end
            end
            REGISTRA:    next_state_s = COMPARACAO;
            COMPARACAO: begin
                if (!bus.igual) begin
                    next_state_s = FIM_ERRO;
                end else if (bus.fimC) begin
                    next_state_s = FIM_ACERTO;
                end else begin
                    next_state_s = PROXIMO;
                end
            end
            PROXIMO:     next_state_s = ESPERA;
            FIM_ACERTO:  next_state_s = bus.iniciar ? PREPARACAO : FIM_ACERTO;
            FIM_ERRO:    next_state_s = bus.iniciar ? PREPARACAO : FIM_ERRO;
            FIM_TIMEOUT: next_state_s = bus.iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:     next_state_s = INICIAL;
        endcase
    end

    // Output decode, registered from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            zera_c_r     <= 1'b1;
            zera_r_r     <= 1'b1;
            conta_c_r    <= 1'b0;
            registra_r_r <= 1'b0;
            pronto_r     <= 1'b0;
            acertou_r    <= 1'b0;
            errou_r      <= 1'b0;
            timeout_r    <= 1'b0;
            db_estado_r  <= ST_INICIAL;
        end else begin
            zera_c_r     <= 1'b0;
            zera_r_r     <= 1'b0;
            conta_c_r    <= 1'b0;
            registra_r_r <= 1'b0;
            pronto_r     <= 1'b0;
            acertou_r    <= 1'b0;
            errou_r      <= 1'b0;
            timeout_r    <= 1'b0;
            case (next_state_s)
                INICIAL, PREPARACAO: begin
                    zera_c_r <= 1'b1;
                    zera_r_r <= 1'b1;
                end
                REGISTRA:    registra_r_r <= 1'b1;
                PROXIMO:     conta_c_r    <= 1'b1;
                FIM_ACERTO: begin
                    pronto_r  <= 1'b1;
                    acertou_r <= 1'b1;
                end
                FIM_ERRO: begin
                    pronto_r <= 1'b1;
                    errou_r  <= 1'b1;
                end
                FIM_TIMEOUT: begin
                    pronto_r  <= 1'b1;
                    timeout_r <= 1'b1;
                end
                default: ;
            endcase
            case (next_state_s)
                INICIAL, PREPARACAO, ESPERA, REGISTRA, COMPARACAO, PROXIMO,
                FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: db_estado_r <= next_state_s;
                default:                            db_estado_r <= DB_ILEGAL;
            endcase
        end
    end

    assign bus.zeraC      = zera_c_r;
    assign bus.zeraR      = zera_r_r;
    assign bus.contaC     = conta_c_r;
    assign bus.registraR  = registra_r_r;
    assign bus.pronto     = pronto_r;
    assign bus.acertou    = acertou_r;
    assign bus.errou      = errou_r;
    assign bus.timeout    = timeout_r;
    assign bus.db_estado  = db_estado_r;
    assign bus.db_timeout = count_s;
endmodule
